// File: rtl/span_cme_pkg.sv
// Shared types and constants for the SPAN CME loader: engine register map,
// bus word types and the loader state encoding.
package span_cme_pkg;

  typedef logic [4:0]  cme_offset_t;
  typedef logic [15:0] cme_word_t;

  // Engine register map (word offsets on the 5-bit register interface)
  localparam cme_offset_t OFF_PSR       = 5'd0;   // PriceScanRange
  localparam cme_offset_t OFF_POS0      = 5'd1;   // first position
  localparam cme_offset_t OFF_POS7      = 5'd8;   // last position, fires scanning risk
  localparam cme_offset_t OFF_MAT0      = 5'd9;   // first maturity
  localparam cme_offset_t OFF_TIER0     = 5'd17;  // first tier maximum
  localparam cme_offset_t OFF_SPREAD0   = 5'd20;  // first spread charge
  localparam cme_offset_t OFF_OUTRIGHT0 = 5'd26;  // first outright rate
  localparam cme_offset_t OFF_OUTRIGHT2 = 5'd28;  // last outright, fires intermonth spread
  localparam cme_offset_t OFF_REARM     = 5'd31;  // unmapped; a write clears engine start flags

  localparam int CME_NUM_REGS      = 29;
  localparam int CME_SETTLE_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REARM   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_READ    = 3'd4,
    ST_CAPTURE = 3'd5
  } loader_state_t;

endpackage

// File: rtl/span_cme_img_ram.sv
// Portfolio image buffer: one write port from the host, one asynchronous
// read port addressed by the loader's burst counter. Contents are not reset.
module span_cme_img_ram
  import span_cme_pkg::*;
#(
  parameter int DEPTH = CME_NUM_REGS
) (
  input  logic        clk,
  input  logic        we,
  input  cme_offset_t waddr,
  input  cme_word_t   wdata,
  input  cme_offset_t raddr,
  output cme_word_t   rdata
);

  cme_word_t mem [DEPTH];

  // Host write; the caller only asserts we for in-range addresses
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range reads return 0 so the read port never indexes past the array
  assign rdata = (raddr < cme_offset_t'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/span_cme_loader.sv
// Memory-mapped initiator for the SPAN CME margin engine: buffers a portfolio
// image, then on start re-arms the engine, bursts the image out in ascending
// offset order, waits for the computation to settle and reads back the margin.
module span_cme_loader
  import span_cme_pkg::*;
#(
  parameter int          NUM_REGS      = CME_NUM_REGS,
  parameter int          SETTLE_CYCLES = CME_SETTLE_CYCLES,
  parameter cme_offset_t REARM_OFFSET  = OFF_REARM
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        img_we,
  input  logic [4:0]  img_addr,
  input  logic [15:0] img_wdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] margin,
  output logic        cme_chipselect,
  output logic        cme_write,
  output logic        cme_read,
  output logic [4:0]  cme_offset,
  output logic [15:0] cme_writeData,
  input  logic [15:0] cme_readData
);

  localparam cme_offset_t LAST_IDX    = cme_offset_t'(NUM_REGS - 1);
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  loader_state_t state_reg, state_next;
  cme_offset_t   index_reg, index_next;
  logic [7:0]    settle_reg, settle_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          cs_reg, cs_next;
  logic          wr_reg, wr_next;
  logic          rd_reg, rd_next;
  cme_offset_t   offset_reg, offset_next;
  cme_word_t     wdata_reg, wdata_next;
  cme_word_t     margin_reg;

  logic          ram_we;
  cme_offset_t   ram_raddr;
  cme_word_t     ram_rdata;

  // The host may only touch the image while idle; out-of-range words are dropped
  assign ram_we = img_we && (state_reg == ST_IDLE) && (img_addr <= LAST_IDX);

  // Read address is the word to be driven on the next cycle: word 0 when
  // leaving REARM, otherwise the successor of the word now on the bus
  assign ram_raddr = (state_reg == ST_LOAD) ? (index_reg + 5'd1) : '0;

  span_cme_img_ram #(
    .DEPTH (NUM_REGS)
  ) u_img_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (img_addr),
    .wdata (img_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Next-state and next-output logic; outputs are computed for the state being
  // entered so that every bus signal leaves the block straight from a flop
  always_comb begin
    state_next  = state_reg;
    index_next  = index_reg;
    settle_next = settle_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    cs_next     = 1'b0;
    wr_next     = 1'b0;
    rd_next     = 1'b0;
    offset_next = offset_reg;
    wdata_next  = wdata_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next  = ST_REARM;
          busy_next   = 1'b1;
          index_next  = '0;
          cs_next     = 1'b1;
          wr_next     = 1'b1;
          offset_next = REARM_OFFSET;
          wdata_next  = '0;
        end
      end
      ST_REARM: begin
        state_next  = ST_LOAD;
        index_next  = '0;
        cs_next     = 1'b1;
        wr_next     = 1'b1;
        offset_next = '0;
        wdata_next  = ram_rdata;
      end
      ST_LOAD: begin
        if (index_reg == LAST_IDX) begin
          state_next  = ST_SETTLE;
          settle_next = SETTLE_LOAD;
        end else begin
          index_next  = index_reg + 5'd1;
          cs_next     = 1'b1;
          wr_next     = 1'b1;
          offset_next = index_reg + 5'd1;
          wdata_next  = ram_rdata;
        end
      end
      ST_SETTLE: begin
        if (settle_reg == 8'd0) begin
          state_next  = ST_READ;
          cs_next     = 1'b1;
          rd_next     = 1'b1;
          offset_next = OFF_PSR;
        end else begin
          settle_next = settle_reg - 8'd1;
        end
      end
      ST_READ: begin
        state_next = ST_CAPTURE;
        done_next  = 1'b1;
        busy_next  = 1'b0;
      end
      ST_CAPTURE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered interface outputs; reset releases the bus at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      index_reg  <= '0;
      settle_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      cs_reg     <= 1'b0;
      wr_reg     <= 1'b0;
      rd_reg     <= 1'b0;
      offset_reg <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      index_reg  <= index_next;
      settle_reg <= settle_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      cs_reg     <= cs_next;
      wr_reg     <= wr_next;
      rd_reg     <= rd_next;
      offset_reg <= offset_next;
      wdata_reg  <= wdata_next;
    end
  end

  // Margin holding register, loaded with the engine's answer during the done cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      margin_reg <= '0;
    end else if (done_reg) begin
      margin_reg <= cme_readData;
    end
  end

  // The engine's readback only becomes available in the done cycle, so the
  // margin is forwarded from the bus then and served from the holding register after
  assign margin         = done_reg ? cme_readData : margin_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign cme_chipselect = cs_reg;
  assign cme_write      = wr_reg;
  assign cme_read       = rd_reg;
  assign cme_offset     = offset_reg;
  assign cme_writeData  = wdata_reg;

endmodule

// File: tb/tb_span_cme_loader.sv
// Self-checking bench for span_cme_loader: table-driven image writes, hand
// sequences for the corner cases and randomized runs against an image model.
module tb_span_cme_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        img_we = 1'b0;
  logic [4:0]  img_addr = '0;
  logic [15:0] img_wdata = '0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [15:0] margin;
  logic        cme_chipselect, cme_write, cme_read;
  logic [4:0]  cme_offset;
  logic [15:0] cme_writeData;
  logic [15:0] cme_readData;

  always #5 clk = ~clk;

  span_cme_loader dut (
    .clk            (clk),
    .reset          (reset),
    .img_we         (img_we),
    .img_addr       (img_addr),
    .img_wdata      (img_wdata),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .margin         (margin),
    .cme_chipselect (cme_chipselect),
    .cme_write      (cme_write),
    .cme_read       (cme_read),
    .cme_offset     (cme_offset),
    .cme_writeData  (cme_writeData),
    .cme_readData   (cme_readData)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- engine model ----------------
  logic [15:0] eng_img [29];
  logic [15:0] rd_q = 16'h0000;
  bit          eng_const = 1'b0;

  function automatic logic [15:0] eng_sum();
    logic [15:0] s = 16'h0000;
    for (int i = 0; i < 29; i++) s = s + eng_img[i];
    return s;
  endfunction

  always @(posedge clk) begin
    if (cme_chipselect && cme_write && cme_offset < 5'd29) eng_img[cme_offset] <= cme_writeData;
    if (cme_chipselect && cme_read) rd_q <= eng_const ? 16'h1234 : eng_sum();
  end
  assign cme_readData = rd_q;

  // ---------------- bus monitor ----------------
  typedef struct {
    int          c;
    logic        wr;
    logic        rd;
    logic [4:0]  off;
    logic [15:0] data;
  } bus_t;
  bus_t bus_q[$];
  int   done_cnt = 0;
  int   both_cnt = 0;

  always @(negedge clk) begin
    bus_t e;
    if (cme_chipselect) begin
      e.c = cyc; e.wr = cme_write; e.rd = cme_read; e.off = cme_offset; e.data = cme_writeData;
      bus_q.push_back(e);
    end
    if (cme_write && cme_read) both_cnt++;
    if (done) done_cnt++;
  end

  // ---------------- reference model ----------------
  logic [15:0] model_img [29];
  logic [15:0] hold_margin = 16'h0000;

  function automatic logic [15:0] model_margin(input bit cst);
    logic [15:0] s = 16'h0000;
    if (cst) return 16'h1234;
    for (int i = 0; i < 29; i++) s = s + model_img[i];
    return s;
  endfunction

  function automatic logic [15:0] spec_val(input int i);
    if (i == 0) return 16'h0000;               // PSR, set to 0x0010 by the start-cycle write
    if (i <= 8) return 16'(i);                 // positions 1..8
    if (i <= 16) return 16'(i - 8);            // maturities 0x01..0x08
    if (i == 17) return 16'd2;
    if (i == 18) return 16'd4;
    if (i == 19) return 16'd8;
    if (i <= 25) return 16'(i - 15);           // spreads 5..10
    return 16'(i - 23);                        // outrights 3,4,5
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [15:0] d, input bit lands);
    img_we = 1'b1; img_addr = a; img_wdata = d;
    @(negedge clk);
    img_we = 1'b0;
    if (lands) model_img[a] = d;
    $display("img write addr=%0d data=0x%04h %s", a, d, lands ? "kept" : "dropped");
  endtask

  // One complete run: start, optional noise while busy, then bus/latency/margin checks
  task automatic do_run(input string tag, input int noise, input bit hold, input bit cst,
                        input bit simul, input logic [4:0] sa, input logic [15:0] sd);
    int k, d0, hold_bad, lat;
    bit got;
    logic [15:0] exp_m;
    logic [22:0] exp_e;
    int exp_c;
    eng_const = cst;
    bus_q.delete();
    d0 = done_cnt; hold_bad = 0; got = 1'b0;
    start = 1'b1; k = cyc;
    if (simul) begin
      img_we = 1'b1; img_addr = sa; img_wdata = sd; model_img[sa] = sd;
    end
    exp_m = model_margin(cst);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      img_we = 1'b0;
      if (i == 0) chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
      if (done) begin got = 1'b1; break; end
      if (margin !== hold_margin) hold_bad++;
      if (noise == 1) begin
        img_we = 1'b1; img_addr = 5'd5; img_wdata = 16'hBEEF;
      end else if (noise == 2) begin
        img_we = 1'($urandom_range(0, 1)); img_addr = 5'($urandom_range(0, 31)); img_wdata = 16'($urandom);
      end
    end
    lat = cyc - k;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'd48);
    chk({tag, "_margin_at_done"}, 32'(margin), 32'(exp_m));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_margin_hold"}, 32'(hold_bad), 32'd0);
    @(negedge clk);
    start = 1'b0;
    hold_margin = exp_m;
    chk({tag, "_margin_after"}, 32'(margin), 32'(exp_m));
    chk({tag, "_bus_count"}, 32'(bus_q.size()), 32'd31);
    for (int j = 0; j < bus_q.size() && j < 31; j++) begin
      if (j == 0) begin
        exp_e = {1'b1, 1'b0, 5'd31, 16'h0000}; exp_c = k + 1;
      end else if (j <= 29) begin
        exp_e = {1'b1, 1'b0, 5'(j - 1), model_img[j - 1]}; exp_c = k + 1 + j;
      end else begin
        exp_e = {1'b0, 1'b1, 5'd0, model_img[28]}; exp_c = k + 47;
      end
      chk({tag, "_bus_xfer"}, 32'({bus_q[j].wr, bus_q[j].rd, bus_q[j].off, bus_q[j].data}), 32'(exp_e));
      chk({tag, "_bus_cycle"}, 32'(bus_q[j].c - k), 32'(exp_c - k));
    end
    repeat (3) @(negedge clk);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    $display("run %s: latency=%0d margin=0x%04h expected=0x%04h xfers=%0d", tag, lat, margin, exp_m, bus_q.size());
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    bit          lands;
  } wvec_t;
  wvec_t tbl [6];

  initial begin
    int d0;
    bit found;
    logic [4:0] ra;

    // ---- reset then idle ----
    #2;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_margin", 32'(margin), 32'd0);
    chk("rst_cs", 32'(cme_chipselect), 32'd0);
    chk("rst_write", 32'(cme_write), 32'd0);
    chk("rst_read", 32'(cme_read), 32'd0);
    chk("rst_offset", 32'(cme_offset), 32'd0);
    chk("rst_wdata", 32'(cme_writeData), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cs", 32'(cme_chipselect), 32'd0);

    // ---- image fill then table-driven writes (out-of-range ones must vanish) ----
    for (int i = 0; i < 29; i++) host_write(5'(i), spec_val(i), 1'b1);
    tbl[0] = '{5'd30, 16'hDEAD, 1'b0};
    tbl[1] = '{5'd29, 16'hCAFE, 1'b0};
    tbl[2] = '{5'd31, 16'hFFFF, 1'b0};
    tbl[3] = '{5'd28, 16'h0005, 1'b1};
    tbl[4] = '{5'd17, 16'h0002, 1'b1};
    tbl[5] = '{5'd30, 16'h0BAD, 1'b0};
    for (int i = 0; i < 6; i++) host_write(tbl[i].addr, tbl[i].data, tbl[i].lands);

    // ---- full run; PSR written in the start cycle must be the one sent ----
    do_run("full", 0, 1'b0, 1'b1, 1'b1, 5'd0, 16'h0010);

    // ---- start held high + image writes to addr 5 while busy ----
    do_run("busy_we", 1, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000);

    // ---- async reset mid-LOAD at offset 12 ----
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cme_write && cme_offset == 5'd12) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("midrst_reached_off12", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_cs", 32'(cme_chipselect), 32'd0);
    chk("midrst_write", 32'(cme_write), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_margin", 32'(margin), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    hold_margin = 16'h0000;
    d0 = done_cnt;
    repeat (60) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    $display("mid-load reset: bus released, done pulses after reset=%0d", done_cnt - d0);

    // ---- recovery run, then back-to-back with a changed position[7] ----
    do_run("after_rst", 0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
    host_write(5'd8, 16'h0042, 1'b1);
    do_run("b2b", 0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);

    // ---- randomized runs ----
    for (int r = 0; r < 6; r++) begin
      int nw;
      nw = $urandom_range(0, 5);
      for (int w = 0; w < nw; w++) begin
        ra = 5'($urandom_range(0, 31));
        host_write(ra, 16'($urandom), ra < 5'd29);
      end
      do_run("rnd", 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 28)), 16'($urandom));
    end

    chk("no_rd_wr_overlap", 32'(both_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d so far)", n_pass, n_total);
    $fatal(1);
  end

endmodule
